fir_mm_arbiter: RTL and testbench
=================================

Name: fir_mm_arbiter

Overview:
Two-master, one-slave Avalon-MM arbiter. It shares the FIR register/coefficient space between the Nios mm_bridge master (m0) and a local coefficient-loader master (m1). Arbitration is round-robin with one outstanding transaction at a time. A read-timeout watchdog stops a stalled slave from locking the bus.

Parameters:
ADDR_W, 10, address width (all ports)
DATA_W, 32, data width; byteenable width = DATA_W/8
RD_TIMEOUT, 255, max cycles in WAIT_RD before forced completion (1..65535)
TIMEOUT_DATA, 32'hDEADBEEF, readdata returned on timeout

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
mX_address  in  ADDR_W  master X address (X = 0, 1; same set for each)
mX_read  in  1  read request
mX_write  in  1  write request
mX_writedata  in  DATA_W  write data
mX_byteenable  in  DATA_W/8  byte enables
mX_waitrequest  out  1  command stall to master X
mX_readdata  out  DATA_W  read data
mX_readdatavalid  out  1  read data valid
s_address  out  ADDR_W  slave address
s_read  out  1  slave read
s_write  out  1  slave write
s_writedata  out  DATA_W  slave write data
s_byteenable  out  DATA_W/8  slave byte enables
s_waitrequest  in  1  slave stall
s_readdata  in  DATA_W  slave read data
s_readdatavalid  in  1  slave read valid
timeout_flag  out  1  sticky: a read timed out
timeout_clr  in  1  clears timeout_flag

Behaviour:
- Reset values: state=IDLE, owner=0, last_grant=1 (so m0 wins the first tie), timeout counter=0, timeout_flag=0. All s_* outputs 0. mX_readdatavalid=0, mX_readdata=0. mX_waitrequest=1 whenever mX_read|mX_write, else 0.
- A request from master X is reqX = mX_read | mX_write. Asserting read and write together is illegal; if it happens, write takes priority.
- FSM states: IDLE, CMD, WAIT_RD.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that master.
  - Both request: grant the master != last_grant.
  - On grant: register owner, set last_grant=owner, go to CMD next cycle.
  - All requesters see waitrequest=1 in IDLE. Minimum arbitration latency is 1 cycle.
- CMD:
  - s_* outputs = owner's command, combinational passthrough from the owner's inputs.
  - owner waitrequest = s_waitrequest. The non-owner sees waitrequest=1 if requesting.
  - Command accepted when s_waitrequest=0. On acceptance: write goes to IDLE; read goes to WAIT_RD with counter cleared.
  - Masters hold their command while waitrequest=1 (Avalon rule). The arbiter does not handle a dropped request.
- WAIT_RD:
  - s_read=s_write=0. Both requesting masters see waitrequest=1.
  - Counter increments each cycle.
  - s_readdatavalid=1: drive owner readdata=s_readdata and readdatavalid=1 in the same cycle (combinational), then go to IDLE.
  - Counter reaches RD_TIMEOUT with no valid: drive owner readdatavalid=1, readdata=TIMEOUT_DATA; set timeout_flag; go to IDLE.
  - Valid and timeout in the same cycle: real data wins and the flag is not set.
- s_readdatavalid outside WAIT_RD (e.g. a late response after timeout) is ignored and never forwarded.
- Non-owner readdatavalid is always 0. mX_readdata is don't-care when its valid=0; the bench must not check it.
- Full transaction cost:
  - Write: 2 cycles minimum (IDLE grant + CMD).
  - Read: 3 cycles minimum with 1-cycle slave latency.
  - Back-to-back requests from one master lose 1 idle cycle between transactions.
- timeout_flag:
  - Set on a timeout event; held until a timeout_clr pulse.
  - Set and clear in the same cycle: set wins.
- Reset asserted mid-transaction: immediate return to IDLE, s_read/s_write drop to 0 asynchronously, and any outstanding read response is discarded.

Test Plan:
- m0 writes 0x12345678 to addr 0x010, slave waitrequest=0 -> s_write high exactly 1 cycle, cycle after request; m0_waitrequest low that cycle; state back to IDLE.
- m1 reads addr 0x3FF, slave waitrequest held high 3 cycles, readdata 0xA5A5A5A5 two cycles after accept -> m1_readdatavalid 1 cycle with 0xA5A5A5A5; m0_readdatavalid stays 0.
- m0 and m1 both issue continuous writes from reset -> grants alternate m0, m1, m0, m1; neither waits more than one other transaction.
- m0 read, slave never asserts readdatavalid, RD_TIMEOUT=8 -> m0_readdatavalid with 0xDEADBEEF after 8 WAIT_RD cycles; timeout_flag=1; a later stray s_readdatavalid is ignored; timeout_clr clears the flag.
- Readdatavalid on the exact timeout cycle -> real data forwarded, timeout_flag stays 0.
- reset_reset_n pulsed low during CMD with s_waitrequest=1 -> s_write=0 immediately; after release, a pending m0 request is granted first (last_grant=1).

Source files
------------

// File: rtl/fir_mm_arbiter.sv
// fir_mm_arbiter: two-master / one-slave Avalon-MM arbiter for the FIR
// register and coefficient space.
//   m0_* : Nios mm_bridge master        m1_* : local coefficient loader
//   s_*  : shared slave port
//   timeout_flag / timeout_clr : sticky read-timeout indicator and its clear
// Round-robin grant, one outstanding transaction. A read that gets no
// readdatavalid within RD_TIMEOUT cycles completes with TIMEOUT_DATA.
module fir_mm_arbiter #(
  parameter int                ADDR_W       = 10,
  parameter int                DATA_W       = 32,
  parameter int                RD_TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic                timeout_flag,
  input  logic                timeout_clr
);
  localparam int BE_W = DATA_W/8;
  // Counter starts at 0 in the first WAIT_RD cycle, so cycle RD_TIMEOUT
  // is the one where it holds RD_TIMEOUT-1.
  localparam logic [15:0] TMO_LAST = 16'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, CMD, WAIT_RD} state_t;

  state_t      r_state, w_next;
  logic        r_owner, r_last, r_flag;
  logic [15:0] r_cnt;

  logic [1:0]             w_rd, w_wr, w_req, w_wait, w_rdv;
  logic [1:0][ADDR_W-1:0] w_addr;
  logic [1:0][DATA_W-1:0] w_wdata, w_rdata;
  logic [1:0][BE_W-1:0]   w_be;
  logic                   w_gnt, w_tmo, w_tmo_evt, w_own_wr, w_own_rd;

  assign w_rd    = {m1_read, m0_read};
  assign w_wr    = {m1_write, m0_write};
  assign w_addr  = {m1_address, m0_address};
  assign w_wdata = {m1_writedata, m0_writedata};
  assign w_be    = {m1_byteenable, m0_byteenable};
  assign w_req   = w_rd | w_wr;

  // Tie goes to whoever did not win last time.
  assign w_gnt    = (&w_req) ? ~r_last : w_req[1];
  // Read+write together is illegal; treat it as a write.
  assign w_own_wr = w_wr[r_owner];
  assign w_own_rd = w_rd[r_owner] & ~w_own_wr;
  assign w_tmo    = (r_cnt == TMO_LAST);

  always_comb begin
    w_next       = r_state;
    s_address    = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_writedata  = '0;
    s_byteenable = '0;
    w_wait       = w_req;
    w_rdv        = '0;
    w_rdata      = '0;
    w_tmo_evt    = 1'b0;
    case (r_state)
      IDLE: if (|w_req) w_next = CMD;
      CMD: begin
        s_address       = w_addr[r_owner];
        s_writedata     = w_wdata[r_owner];
        s_byteenable    = w_be[r_owner];
        s_write         = w_own_wr;
        s_read          = w_own_rd;
        w_wait[r_owner] = s_waitrequest;
        if (!s_waitrequest) w_next = w_own_rd ? WAIT_RD : IDLE;
      end
      WAIT_RD: begin
        // Real data beats a timeout landing in the same cycle.
        if (s_readdatavalid) begin
          w_rdv[r_owner]   = 1'b1;
          w_rdata[r_owner] = s_readdata;
          w_next           = IDLE;
        end else if (w_tmo) begin
          w_rdv[r_owner]   = 1'b1;
          w_rdata[r_owner] = TIMEOUT_DATA;
          w_tmo_evt        = 1'b1;
          w_next           = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && |w_req) begin
        r_owner <= w_gnt;
        r_last  <= w_gnt;
      end
      r_cnt <= (r_state == WAIT_RD) ? r_cnt + 16'd1 : '0;
      if (w_tmo_evt)        r_flag <= 1'b1;
      else if (timeout_clr) r_flag <= 1'b0;
    end
  end

  assign m0_waitrequest   = w_wait[0];
  assign m1_waitrequest   = w_wait[1];
  assign m0_readdatavalid = w_rdv[0];
  assign m1_readdatavalid = w_rdv[1];
  assign m0_readdata      = w_rdata[0];
  assign m1_readdata      = w_rdata[1];
  assign timeout_flag     = r_flag;
endmodule

// File: tb/tb_fir_mm_arbiter.sv
// Bench for fir_mm_arbiter: directed scenarios followed by randomized
// two-master traffic against a transaction-level model of the arbiter.
module tb_fir_mm_arbiter;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  m_addr[2];
  logic        m_rd[2], m_wr[2];
  logic [31:0] m_wd[2];
  logic [3:0]  m_be[2];
  logic        m_wait[2], m_rdv[2];
  logic [31:0] m_rdata[2];
  logic [9:0]  s_address;
  logic        s_read, s_write, s_wait, s_rdv;
  logic [31:0] s_writedata, s_rdata;
  logic [3:0]  s_byteenable;
  logic        tflag, tclr;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fir_mm_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_TIMEOUT(TMO), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .m0_address(m_addr[0]), .m0_read(m_rd[0]), .m0_write(m_wr[0]), .m0_writedata(m_wd[0]),
    .m0_byteenable(m_be[0]), .m0_waitrequest(m_wait[0]), .m0_readdata(m_rdata[0]),
    .m0_readdatavalid(m_rdv[0]),
    .m1_address(m_addr[1]), .m1_read(m_rd[1]), .m1_write(m_wr[1]), .m1_writedata(m_wd[1]),
    .m1_byteenable(m_be[1]), .m1_waitrequest(m_wait[1]), .m1_readdata(m_rdata[1]),
    .m1_readdatavalid(m_rdv[1]),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_waitrequest(s_wait), .s_readdata(s_rdata),
    .s_readdatavalid(s_rdv), .timeout_flag(tflag), .timeout_clr(tclr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_rd[i] = 0; m_wr[i] = 0; m_wd[i] = '0; m_be[i] = '0;
    end
    s_wait = 0; s_rdv = 0; s_rdata = '0; tclr = 0;
  endtask

  // Ends just after a rising edge with reset released and the arbiter idle.
  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    @(negedge clk); @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  // Grant + accept a read with no slave stall; returns at the start of WAIT cycle 1.
  task automatic issue_read(input int m, input logic [9:0] a);
    m_addr[m] = a; m_be[m] = 4'hF; m_rd[m] = 1; s_wait = 0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk); chk("rd accept", m_wait[m], 0);
    @(posedge clk); #1; m_rd[m] = 0;
  endtask

  // Number of WAIT cycles until master m sees readdatavalid (0 = never).
  task automatic wait_rdv(input int m, output int n);
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      chk("other rdv", m_rdv[1-m], 0);
      if (m_rdv[m]) begin n = k; break; end
      @(posedge clk); #1;
    end
  endtask

  // Random-phase model state
  bit          act[2], rdp[2], acc[2];
  int          rd_cyc[2], rd_lat[2], wcnt[2], loss[2];
  logic [31:0] rd_dat[2];
  logic        exp_flag;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n, nw, tcyc, nacc;
    bit gen, evt, ev;
    logic [9:0] wa[4];
    int wt[4];

    // ---------------- reset state ----------------
    idle_inputs();
    rst_n = 0;
    m_wr[0] = 1; m_addr[0] = 10'h3FF; m_wd[0] = 32'hFFFFFFFF; m_be[0] = 4'hF;
    s_rdv = 1; s_rdata = 32'h11112222;
    #12;
    chk("rst m0_wait", m_wait[0], 1);
    chk("rst m1_wait", m_wait[1], 0);
    chk("rst s_write", s_write, 0);
    chk("rst s_read", s_read, 0);
    chk("rst s_addr", s_address, 0);
    chk("rst s_wdata", s_writedata, 0);
    chk("rst s_be", s_byteenable, 0);
    chk("rst m0_rdv", m_rdv[0], 0);
    chk("rst m1_rdv", m_rdv[1], 0);
    chk("rst m0_rdata", m_rdata[0], 0);
    chk("rst flag", tflag, 0);
    idle_inputs();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // ---------------- m0 single write ----------------
    m_addr[0] = 10'h010; m_wd[0] = 32'h12345678; m_be[0] = 4'hF; m_wr[0] = 1;
    @(negedge clk);
    chk("w idle wait", m_wait[0], 1);
    chk("w idle s_write", s_write, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w cmd s_write", s_write, 1);
    chk("w cmd s_addr", s_address, 10'h010);
    chk("w cmd s_wdata", s_writedata, 32'h12345678);
    chk("w cmd wait", m_wait[0], 0);
    @(posedge clk); #1; m_wr[0] = 0;
    @(negedge clk);
    chk("w after s_write", s_write, 0);
    chk("w after wait", m_wait[0], 0);

    // ---------------- m1 read with slave stall ----------------
    @(posedge clk); #1;
    m_addr[1] = 10'h3FF; m_be[1] = 4'hF; m_rd[1] = 1; s_wait = 1;
    @(negedge clk); chk("r idle wait", m_wait[1], 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("r stall s_read", s_read, 1);
      chk("r stall s_addr", s_address, 10'h3FF);
      chk("r stall wait", m_wait[1], 1);
    end
    @(posedge clk); #1; s_wait = 0;
    @(negedge clk); chk("r accept wait", m_wait[1], 0);
    @(posedge clk); #1; m_rd[1] = 0;
    @(negedge clk);
    chk("r wait1 rdv", m_rdv[1], 0);
    chk("r wait1 s_read", s_read, 0);
    @(posedge clk); #1; s_rdv = 1; s_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("r rdv", m_rdv[1], 1);
    chk("r rdata", m_rdata[1], 32'hA5A5A5A5);
    chk("r m0 rdv", m_rdv[0], 0);
    @(posedge clk); #1; s_rdv = 0;
    @(negedge clk); chk("r rdv once", m_rdv[1], 0);

    // ---------------- both continuous writes ----------------
    do_reset();
    m_addr[0] = 10'h100; m_wd[0] = 32'hA0A0A0A0; m_be[0] = 4'h3; m_wr[0] = 1;
    m_addr[1] = 10'h200; m_wd[1] = 32'hB1B1B1B1; m_be[1] = 4'hC; m_wr[1] = 1;
    nw = 0;
    for (int c = 0; c < 20 && nw < 4; c++) begin
      @(negedge clk);
      if (s_write) begin wa[nw] = s_address; wt[nw] = c; nw++; end
      if (nw < 4) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1; m_wr[0] = 0; m_wr[1] = 0;
    chk("rr count", nw, 4);
    for (int k = 0; k < 4; k++) begin
      chk("rr order", (k < nw) ? wa[k] : 10'h0, (k % 2 == 0) ? 10'h100 : 10'h200);
      if (k > 0) chk("rr gap", (k < nw) ? wt[k] - wt[k-1] : 0, 2);
    end

    // ---------------- read timeout, stray valid, clear ----------------
    @(posedge clk); #1;
    issue_read(0, 10'h020);
    wait_rdv(0, n);
    chk("tmo cycles", n, TMO);
    chk("tmo data", m_rdata[0], 32'hDEADBEEF);
    chk("tmo flag pre", tflag, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("tmo flag set", tflag, 1);
    @(posedge clk); #1; s_rdv = 1; s_rdata = 32'h00001234;
    @(negedge clk);
    chk("stray m0", m_rdv[0], 0);
    chk("stray m1", m_rdv[1], 0);
    @(posedge clk); #1; s_rdv = 0; tclr = 1;
    @(negedge clk); chk("clr pending", tflag, 1);
    @(posedge clk); #1; tclr = 0;
    @(negedge clk); chk("clr done", tflag, 0);

    // timeout while clear is held: set wins
    @(posedge clk); #1;
    issue_read(1, 10'h021);
    tclr = 1;
    wait_rdv(1, n);
    chk("tmo2 cycles", n, TMO);
    @(posedge clk); #1; tclr = 0;
    @(negedge clk); chk("set wins", tflag, 1);
    @(posedge clk); #1; tclr = 1;
    @(posedge clk); #1; tclr = 0;
    @(negedge clk); chk("clr2", tflag, 0);

    // ---------------- valid on the timeout cycle ----------------
    @(posedge clk); #1;
    issue_read(0, 10'h022);
    for (int k = 1; k <= TMO; k++) begin
      if (k == TMO) begin s_rdv = 1; s_rdata = 32'hC0FFEE11; end
      @(negedge clk);
      chk("edge rdv", m_rdv[0], (k == TMO) ? 1 : 0);
      if (k == TMO) chk("edge data", m_rdata[0], 32'hC0FFEE11);
      @(posedge clk); #1; s_rdv = 0;
    end
    @(negedge clk); chk("edge flag", tflag, 0);

    // ---------------- reset during CMD ----------------
    do_reset();
    m_addr[0] = 10'h055; m_wd[0] = 32'h55555555; m_be[0] = 4'hF; m_wr[0] = 1;
    m_addr[1] = 10'h0AA; m_wd[1] = 32'hAAAAAAAA; m_be[1] = 4'hF; m_wr[1] = 1;
    s_wait = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rc cmd s_write", s_write, 1);
    chk("rc cmd owner", s_address, 10'h055);
    #2 rst_n = 0;
    #1 chk("rc async s_write", s_write, 0);
    @(posedge clk); @(negedge clk); rst_n = 1; s_wait = 0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (s_write) begin n = 1; break; end
    end
    chk("rc regrant seen", n, 1);
    chk("rc regrant m0", s_address, 10'h055);
    @(posedge clk); #1; idle_inputs();

    // ---------------- randomized traffic ----------------
    do_reset();
    exp_flag = 0;
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; rdp[i] = 0; rd_cyc[i] = 0; rd_lat[i] = 0; wcnt[i] = 0; loss[i] = 0;
    end
    for (int cyc = 0; cyc < 2200; cyc++) begin
      gen = (cyc < 2100);
      @(negedge clk);
      chk("rnd flag", tflag, exp_flag);
      evt = 0; nacc = 0;
      for (int i = 0; i < 2; i++) begin
        acc[i] = 0;
        if (rdp[i]) begin
          rd_cyc[i]++;
          tcyc = (rd_lat[i] < TMO) ? rd_lat[i] : TMO;
          ev = (rd_cyc[i] == tcyc);
          chk("rnd rdv", m_rdv[i], ev);
          if (ev) begin
            chk("rnd rdata", m_rdata[i], (rd_lat[i] <= TMO) ? rd_dat[i] : 32'hDEADBEEF);
            if (rd_lat[i] > TMO) evt = 1;
            rdp[i] = 0;
          end
        end else chk("rnd rdv idle", m_rdv[i], 0);
        if (!act[i]) chk("rnd idle wait", m_wait[i], 0);
        else if (!m_wait[i]) begin
          acc[i] = 1; nacc++;
          chk("rnd s_addr", s_address, m_addr[i]);
          chk("rnd s_be", s_byteenable, m_be[i]);
          chk("rnd s_write", s_write, m_wr[i]);
          chk("rnd s_read", s_read, !m_wr[i]);
          if (m_wr[i]) chk("rnd s_wdata", s_writedata, m_wd[i]);
          if (act[1-i]) begin chk("rnd fair", loss[1-i], 0); loss[1-i]++; end
          loss[i] = 0; wcnt[i] = 0;
        end else begin
          wcnt[i]++;
          if (wcnt[i] > 100) begin chk("rnd starve", wcnt[i], 0); act[i] = 0; m_rd[i] = 0; m_wr[i] = 0; end
        end
      end
      chk("rnd one accept", nacc <= 1, 1);
      if ((s_read || s_write) && !s_wait) chk("rnd orphan cmd", nacc, 1);
      if (evt) exp_flag = 1; else if (tclr) exp_flag = 0;

      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          if (!m_wr[i]) begin
            rdp[i] = 1; rd_cyc[i] = 0;
            rd_lat[i] = $urandom_range(1, 11); rd_dat[i] = $urandom;
          end
          act[i] = 0; m_rd[i] = 0; m_wr[i] = 0;
        end
        if (gen && !act[i] && !rdp[i] && $urandom_range(0, 2) == 0) begin
          n = $urandom_range(0, 9);
          act[i] = 1;
          m_addr[i] = 10'($urandom); m_wd[i] = $urandom; m_be[i] = 4'($urandom);
          m_rd[i] = (n <= 4 || n == 9); m_wr[i] = (n >= 5);
        end
      end
      s_wait = ($urandom_range(0, 2) == 0);
      s_rdv = 0; s_rdata = $urandom;
      for (int i = 0; i < 2; i++)
        if (rdp[i] && rd_cyc[i] + 1 == rd_lat[i]) begin s_rdv = 1; s_rdata = rd_dat[i]; end
      tclr = ($urandom_range(0, 15) == 0);
    end
    chk("rnd drained", {30'd0, act[0] | act[1], rdp[0] | rdp[1]}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
